// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Optional rotate support is enabled by defining SHIFTER_ROTATE_EN.
package shifter_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_op_t;

  // One conditional shift layer per bit of the shift amount.
  function automatic int unsigned layer_count(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mux2.sv
// Single-bit two-input multiplexer; the leaf cell of every shift layer.
module mux2 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/shift_layer.sv
// One combinational barrel-shifter layer: shifts by 2^K when en is set.
// Wrap-around for rotate is built only when SHIFTER_ROTATE_EN is defined.
module shift_layer
  import shifter_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned K = 0
) (
  input  logic [N-1:0] data,
  input  logic         en,
  input  shift_op_t    op,
  input  logic         fill,
  output logic [N-1:0] out
);

  localparam int unsigned S = 1 << K;

  logic go_left;
  logic right_fill;

  assign go_left    = (op == SHIFT_SLL);
  // Only SRA brings in the sign bit; SRL (and ROR without wrap) fill with zero.
  assign right_fill = (op == SHIFT_SRA) & fill;

  for (genvar i = 0; i < N; i++) begin : g_bit
    logic left_bit;
    logic right_bit;
    logic shifted;

    if (i >= S) begin : g_left_src
      assign left_bit = data[i-S];
    end else begin : g_left_zero
      assign left_bit = 1'b0;
    end

    if (i + S < N) begin : g_right_src
      assign right_bit = data[i+S];
    end else begin : g_right_edge
`ifdef SHIFTER_ROTATE_EN
      assign right_bit = (op == SHIFT_ROR) ? data[i+S-N] : right_fill;
`else
      assign right_bit = right_fill;
`endif
    end

    mux2 u_dir (
      .a  (right_bit),
      .b  (left_bit),
      .sel(go_left),
      .y  (shifted)
    );

    mux2 u_en (
      .a  (data[i]),
      .b  (shifted),
      .sel(en),
      .y  (out[i])
    );
  end

endmodule

// File: rtl/shifter_pipelined.sv
// Two-stage pipelined logical/arithmetic barrel shifter with valid/ready on both sides.
// Define SHIFTER_ROTATE_EN to make op 11 rotate right; otherwise op 11 yields zero.
module shifter_pipelined
  import shifter_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned SPLIT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [N-1:0]         i_data,
  input  logic [$clog2(N)-1:0] i_shamt,
  input  shift_op_t            i_op,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [N-1:0]         o_data
);

  localparam int unsigned LW = layer_count(N);
  localparam int unsigned RW = LW - SPLIT;

  if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("shifter_pipelined: N must be a power of 2 and at least 4");
  end
  if (SPLIT < 1 || SPLIT >= LW) begin : g_bad_split
    $error("shifter_pipelined: SPLIT must satisfy 1 <= SPLIT < log2(N)");
  end

  // Stage registers
  logic          s1_valid_q;
  logic [N-1:0]  s1_data_q;
  logic [RW-1:0] s1_shamt_q;
  shift_op_t     s1_op_q;
  logic          s1_sign_q;
  logic          s2_valid_q;
  logic [N-1:0]  s2_data_q;

  logic adv1;
  logic adv2;

  assign adv2    = !s2_valid_q | i_ready;
  assign adv1    = !s1_valid_q | adv2;
  assign o_ready = adv1;
  assign o_valid = s2_valid_q;
  assign o_data  = s2_data_q;

  // Stage 1: low-order layers applied to the incoming operand.
  logic [N-1:0] s1_in;
  logic [N-1:0] l1 [SPLIT+1];

`ifdef SHIFTER_ROTATE_EN
  assign s1_in = i_data;
`else
  // Without rotate hardware, op 11 shifts a zero operand so the result is zero.
  assign s1_in = (i_op == SHIFT_ROR) ? '0 : i_data;
`endif

  assign l1[0] = s1_in;

  for (genvar k = 0; k < SPLIT; k++) begin : g_st1
    shift_layer #(
      .N(N),
      .K(k)
    ) u_layer (
      .data(l1[k]),
      .en  (i_shamt[k]),
      .op  (i_op),
      .fill(i_data[N-1]),
      .out (l1[k+1])
    );
  end

  // Stage 2: remaining layers applied to the S1 partial result.
  logic [N-1:0] l2 [RW+1];

  assign l2[0] = s1_data_q;

  for (genvar j = 0; j < RW; j++) begin : g_st2
    shift_layer #(
      .N(N),
      .K(SPLIT + j)
    ) u_layer (
      .data(l2[j]),
      .en  (s1_shamt_q[j]),
      .op  (s1_op_q),
      .fill(s1_sign_q),
      .out (l2[j+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_shamt_q <= '0;
      s1_op_q    <= SHIFT_SLL;
      s1_sign_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      if (adv1) begin
        s1_valid_q <= i_valid;
        if (i_valid) begin
          s1_data_q  <= l1[SPLIT];
          s1_shamt_q <= i_shamt[LW-1:SPLIT];
          s1_op_q    <= i_op;
          s1_sign_q  <= i_data[N-1];
        end
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= l2[RW];
        end
      end
    end
  end

endmodule

// File: tb/tb_shifter_pipelined.sv
// Directed self-checking bench for shifter_pipelined (N=32, SPLIT=2).
// Op 11 expectations follow SHIFTER_ROTATE_EN.
module tb_shifter_pipelined;
  import shifter_pkg::*;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data;
  logic [4:0]  i_shamt;
  shift_op_t   i_op;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;

  int checks;
  int errors;

  shifter_pipelined #(
    .N    (32),
    .SPLIT(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data (i_data),
    .i_shamt(i_shamt),
    .i_op   (i_op),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data (o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request into an empty pipe and capture what appears two cycles later.
  task automatic run_one(input logic [31:0] d, input logic [4:0] sh, input shift_op_t op,
                         output logic vld, output logic [31:0] res);
    i_valid = 1'b1;
    i_data  = d;
    i_shamt = sh;
    i_op    = op;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    vld = o_valid;
    res = o_data;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'h1234_5678;
    i_shamt = 5'd3;
    i_op    = SHIFT_SLL;
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", o_valid);
    end
    checks++;
    if (o_data !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 00000000", o_data);
    end
    checks++;
    if (o_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", o_ready);
    end
    rst     = 1'b1;
    i_data  = 32'h0000_0001;
    i_shamt = 5'd1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL first_latency_early: got %b expected 0", o_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b1 || o_data !== 32'h0000_0002) begin
      errors++;
      $display("FAIL first_latency: got valid=%b data=%h expected valid=1 data=00000002",
               o_valid, o_data);
    end
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL first_drain: got %b expected 0", o_valid);
    end
  endtask

  task automatic test_basic_ops();
    logic        vld;
    logic [31:0] res;
    shift_op_t   ops [3];
    logic [31:0] exp [3];
    ops = '{SHIFT_SLL, SHIFT_SRL, SHIFT_SRA};
    exp = '{32'h0000_0F10, 32'h0800_000F, 32'hF800_000F};
    for (int k = 0; k < 3; k++) begin
      run_one(32'h8000_00F1, 5'd4, ops[k], vld, res);
      checks++;
      if (vld !== 1'b1 || res !== exp[k]) begin
        errors++;
        $display("FAIL basic_op%0d: got valid=%b data=%h expected valid=1 data=%h",
                 k, vld, res, exp[k]);
      end
    end
  endtask

  task automatic test_boundaries();
    logic        vld;
    logic [31:0] res;
    shift_op_t   ops [3];
    ops = '{SHIFT_SLL, SHIFT_SRL, SHIFT_SRA};
    for (int k = 0; k < 3; k++) begin
      run_one(32'hDEAD_BEEF, 5'd0, ops[k], vld, res);
      checks++;
      if (vld !== 1'b1 || res !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL shamt0_op%0d: got valid=%b data=%h expected valid=1 data=deadbeef",
                 k, vld, res);
      end
    end
    run_one(32'h8000_0000, 5'd31, SHIFT_SRA, vld, res);
    checks++;
    if (res !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL sra31: got %h expected ffffffff", res);
    end
    run_one(32'h0000_0001, 5'd31, SHIFT_SLL, vld, res);
    checks++;
    if (res !== 32'h8000_0000) begin
      errors++; $display("FAIL sll31: got %h expected 80000000", res);
    end
    run_one(32'h8000_0000, 5'd31, SHIFT_SRL, vld, res);
    checks++;
    if (res !== 32'h0000_0001) begin
      errors++; $display("FAIL srl31: got %h expected 00000001", res);
    end
    run_one(32'h7000_0000, 5'd29, SHIFT_SRA, vld, res);
    checks++;
    if (res !== 32'h0000_0003) begin
      errors++; $display("FAIL sra_pos: got %h expected 00000003", res);
    end
  endtask

  task automatic test_op11();
    logic        vld;
    logic [31:0] res;
    run_one(32'h0000_0001, 5'd1, SHIFT_ROR, vld, res);
    checks++;
`ifdef SHIFTER_ROTATE_EN
    if (vld !== 1'b1 || res !== 32'h8000_0000) begin
      errors++;
      $display("FAIL ror1: got valid=%b data=%h expected valid=1 data=80000000", vld, res);
    end
    run_one(32'h1234_5678, 5'd8, SHIFT_ROR, vld, res);
    checks++;
    if (res !== 32'h7812_3456) begin
      errors++; $display("FAIL ror8: got %h expected 78123456", res);
    end
    run_one(32'hDEAD_BEEF, 5'd0, SHIFT_ROR, vld, res);
    checks++;
    if (res !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ror0: got %h expected deadbeef", res);
    end
`else
    if (vld !== 1'b1 || res !== 32'h0000_0000) begin
      errors++;
      $display("FAIL op11_zero: got valid=%b data=%h expected valid=1 data=00000000", vld, res);
    end
    run_one(32'hFFFF_FFFF, 5'd0, SHIFT_ROR, vld, res);
    checks++;
    if (vld !== 1'b1 || res !== 32'h0000_0000) begin
      errors++;
      $display("FAIL op11_zero_s0: got valid=%b data=%h expected valid=1 data=00000000",
               vld, res);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [8];
    exp = '{32'h0000_00FF, 32'h0000_01FE, 32'h0000_03FC, 32'h0000_07F8,
            32'h0000_0FF0, 32'h0000_1FE0, 32'h0000_3FC0, 32'h0000_7F80};
    i_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      checks++;
      if (c < 2 || c > 9) begin
        if (o_valid !== 1'b0) begin
          errors++; $display("FAIL b2b_idle_c%0d: got valid=%b expected 0", c, o_valid);
        end
      end else if (o_valid !== 1'b1 || o_data !== exp[c-2]) begin
        errors++;
        $display("FAIL b2b_res%0d: got valid=%b data=%h expected valid=1 data=%h",
                 c - 2, o_valid, o_data, exp[c-2]);
      end
      if (c < 8) begin
        i_valid = 1'b1;
        i_data  = 32'h0000_00FF;
        i_shamt = 5'(c);
        i_op    = SHIFT_SLL;
      end else begin
        i_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'h0000_0001;
    i_shamt = 5'd1;
    i_op    = SHIFT_SLL;
    @(posedge clk); #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++; $display("FAIL stall_fill_ready: got %b expected 1", o_ready);
    end
    i_data  = 32'h8000_0000;
    i_shamt = 5'd4;
    i_op    = SHIFT_SRA;
    @(posedge clk); #1;
    i_data  = 32'h0000_00F0;
    i_shamt = 5'd4;
    i_op    = SHIFT_SRL;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== 32'h0000_0002 || o_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_c%0d: got valid=%b data=%h ready=%b expected 1/00000002/0",
                 c, o_valid, o_data, o_ready);
      end
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release_ready: got %b expected 1", o_ready);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_data !== 32'hF800_0000) begin
      errors++;
      $display("FAIL stall_second: got valid=%b data=%h expected valid=1 data=f8000000",
               o_valid, o_data);
    end
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b1 || o_data !== 32'h0000_000F) begin
      errors++;
      $display("FAIL stall_third: got valid=%b data=%h expected valid=1 data=0000000f",
               o_valid, o_data);
    end
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL stall_drain: got %b expected 0", o_valid);
    end
  endtask

  task automatic test_flush();
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_data  = 32'h0000_0003;
    i_shamt = 5'd2;
    i_op    = SHIFT_SLL;
    @(posedge clk); #1;
    i_valid = 1'b0;
    rst     = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (o_valid !== 1'b0) begin
        errors++; $display("FAIL flush_c%0d: got valid=%b expected 0", c, o_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_shamt = '0;
    i_op    = SHIFT_SLL;
    i_ready = 1'b1;
    test_reset();
    test_basic_ops();
    test_boundaries();
    test_op11();
    test_back_to_back();
    test_stall();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
